// File: rtl/abcd_w_pkg.sv
// Shared constants and reference model for the W = (A & ~B) | (C & D) unit.
package abcd_w_pkg;

    localparam logic [15:0] W_TRUTH       = 16'h8F88;
    localparam int          CNT_W_DEFAULT = 16;

    // Truth-table lookup; index is {a,b,c,d} with a as MSB.
    function automatic logic w_ref(input logic a, input logic b, input logic c, input logic d);
        logic [15:0] tt;
        tt = W_TRUTH;
        return tt[{a, b, c, d}];
    endfunction

endpackage

// File: rtl/abcd_w_gate_netlist.sv
// Primitive-gate realisation of W = (A & ~B) | (C & D); no behavioural operators.
module w_gate_netlist (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output wire  w
);

    wire b_n;
    wire a_and_bn;
    wire c_and_d;

    not u_not_b  (b_n,      b);
    and u_and_ab (a_and_bn, a, b_n);
    and u_and_cd (c_and_d,  c, d);
    or  u_or_w   (w,        a_and_bn, c_and_d);

endmodule

// File: rtl/abcd_w_logic.sv
// Behavioural and gate-level W computed side by side; a registered comparator
// flags any disagreement and a saturating counter tracks captures.
module abcd_w_logic
    import abcd_w_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    output logic             w,
    output logic             w_q,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] sample_cnt
);

    logic w_beh;
    logic w_str;
    logic diff;

    assign w_beh = (a & ~b) | (c & d);
    assign w     = w_beh;

    w_gate_netlist u_gate (
        .a (a),
        .b (b),
        .c (c),
        .d (d),
        .w (w_str)
    );

    assign diff = w_beh ^ w_str;

    // NOTE: state updates use <= so every register samples pre-edge values,
    // independent of statement order; reset is synchronous and wins over sample_en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_q        <= 1'b0;
            mismatch   <= 1'b0;
            err_sticky <= 1'b0;
            sample_cnt <= '0;
        end else if (sample_en) begin
            w_q        <= w_beh;
            mismatch   <= diff;
            err_sticky <= err_sticky | diff;
            if (sample_cnt != {CNT_W{1'b1}})
                sample_cnt <= sample_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_abcd_w_logic.sv
// Directed bench for abcd_w_logic: reset, exhaustive sweep, hold, random,
// forced gate-path fault and counter saturation on a narrow instance.
module tb_abcd_w_logic;
    import abcd_w_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, sample_en;
    logic        rst_n2, sample_en2;
    logic        a, b, c, d;

    logic        w, w_q, mismatch, err_sticky;
    logic [15:0] sample_cnt;
    logic        w2, w_q2, mismatch2, err_sticky2;
    logic [1:0]  sample_cnt2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    abcd_w_logic #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en),
        .a(a), .b(b), .c(c), .d(d),
        .w(w), .w_q(w_q), .mismatch(mismatch),
        .err_sticky(err_sticky), .sample_cnt(sample_cnt)
    );

    abcd_w_logic #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n2), .sample_en(sample_en2),
        .a(a), .b(b), .c(c), .d(d),
        .w(w2), .w_q(w_q2), .mismatch(mismatch2),
        .err_sticky(err_sticky2), .sample_cnt(sample_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_abcd(input logic [3:0] v);
        {a, b, c, d} = v;
    endtask

    logic [15:0] hand_tt;
    logic [3:0]  v;
    logic        exp_w;
    logic [1:0]  sat_exp [5];

    initial begin
        hand_tt = 16'h8F88;
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst_n = 1'b0; sample_en = 1'b1;
        rst_n2 = 1'b0; sample_en2 = 1'b0;
        set_abcd(4'b1111);

        // Reset held for two edges with sample_en asserted
        tick(); tick();
        check("rst_w_q",      32'(w_q),        32'd0);
        check("rst_mismatch", 32'(mismatch),   32'd0);
        check("rst_err",      32'(err_sticky), 32'd0);
        check("rst_cnt",      32'(sample_cnt), 32'd0);
        check("rst_w_comb",   32'(w),          32'd1);

        // Exhaustive sweep
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            set_abcd(v);
            #1;
            check($sformatf("sweep_w_%b", v), 32'(w), 32'(hand_tt[v]));
            tick();
            check($sformatf("sweep_wq_%b", v), 32'(w_q), 32'(hand_tt[v]));
            check($sformatf("sweep_mm_%b", v), 32'(mismatch), 32'd0);
        end
        check("sweep_cnt", 32'(sample_cnt), 32'd16);
        check("sweep_err", 32'(err_sticky), 32'd0);

        // Hold: w follows inputs, registers frozen
        sample_en = 1'b0;
        set_abcd(4'b1000); #1;
        check("hold_w_1000", 32'(w), 32'd1);
        set_abcd(4'b0000); #1;
        check("hold_w_0000", 32'(w), 32'd0);
        tick();
        check("hold_w_q", 32'(w_q),        32'd1);
        check("hold_cnt", 32'(sample_cnt), 32'd16);

        // Random captures after a fresh reset
        rst_n = 1'b0; sample_en = 1'b1;
        tick();
        check("rst2_cnt", 32'(sample_cnt), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            v = 4'($urandom_range(15, 0));
            set_abcd(v);
            exp_w = w_ref(v[3], v[2], v[1], v[0]);
            tick();
            check($sformatf("rand_wq_%0d_%b", i, v), 32'(w_q), 32'(exp_w));
        end
        check("rand_err", 32'(err_sticky), 32'd0);
        check("rand_cnt", 32'(sample_cnt), 32'd20);

        // Fault injection on the gate path
        set_abcd(4'b0111);
        force dut.w_str = 1'b0;
        tick();
        check("fault_mm",  32'(mismatch),   32'd1);
        check("fault_err", 32'(err_sticky), 32'd1);
        check("fault_wq",  32'(w_q),        32'd1);
        release dut.w_str;
        set_abcd(4'b0000);
        tick();
        check("clear_mm",  32'(mismatch),   32'd0);
        check("clear_err", 32'(err_sticky), 32'd1);
        check("clear_cnt", 32'(sample_cnt), 32'd22);

        // Mid-operation reset with sample_en high
        set_abcd(4'b1111);
        rst_n = 1'b0;
        tick();
        check("midrst_wq",  32'(w_q),        32'd0);
        check("midrst_err", 32'(err_sticky), 32'd0);
        check("midrst_cnt", 32'(sample_cnt), 32'd0);
        rst_n = 1'b1;

        // Saturation on the 2-bit counter instance
        rst_n2 = 1'b1; sample_en2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("sat_cnt_%0d", i), 32'(sample_cnt2), 32'(sat_exp[i]));
        end
        rst_n2 = 1'b0;
        tick();
        check("sat_rst_cnt", 32'(sample_cnt2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
